uart_rx_param: RTL and testbench

Parametrised UART receiver, successor to the fixed 8-bit/9-tick receiver. It adds configurable data width, parity mode, stop-bit count, oversampling ratio and clock divider, together with an input synchroniser, 3-sample majority voting and false-start rejection. It reports parity, framing and overrun errors. Received frames go to the consumer over the existing 4-phase req/ack handshake, and the block sits between the serial input pin and the byte consumer.

---
 rtl/uart_rx_param.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, 3-sample majority vote,
// false-start rejection, parity/framing/overrun flags, 4-phase req/ack.
module uart_rx_param #(
    parameter int DIV       = 1,
    parameter int OS        = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 rcv,
    input  logic                 ack,
    output logic                 req,
    output logic [DATA_BITS-1:0] data,
    output logic                 perr,
    output logic                 ferr,
    output logic                 overrun
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW = $clog2(OS);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [OW-1:0] OS_LAST  = OW'(OS - 1);
    localparam logic [OW-1:0] V0       = OW'(OS / 2 - 1);
    localparam logic [OW-1:0] V1       = OW'(OS / 2);
    localparam logic [OW-1:0] V2       = OW'(OS / 2 + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          HAS_PAR  = (PARITY != 0);
    localparam logic          ODD      = (PARITY == 2);
    localparam logic          STOP_LST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                 sync_q, rs_q;
    logic [DW-1:0]        div_q;
    logic                 tick;
    logic                 ack_q;
    logic                 s0_q, s1_q;
    logic                 vote;
    logic                 vote_tick;
    logic                 wrap;

    logic [OW-1:0]        os_q, os_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stp_q, stp_d;
    logic [DATA_BITS-1:0] shf_q, shf_d;
    logic                 perr_int_q, perr_int_d;
    logic                 ferr_int_q, ferr_int_d;

    logic                 req_q, req_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= 1'b1;
            rs_q   <= 1'b1;
        end else begin
            sync_q <= rcv;
            rs_q   <= sync_q;
        end
    end

    assign tick = (div_q == DIV_LAST);

    // Free-running sample-tick divider.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
        end
    end

    // Registered ack, used to qualify a new load.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack;
        end
    end

    // Capture the two early vote samples around mid-bit.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else if (tick) begin
            if (os_q == V0) s0_q <= rs_q;
            if (os_q == V1) s1_q <= rs_q;
        end
    end

    assign vote      = (s0_q & s1_q) | (s0_q & rs_q) | (s1_q & rs_q);
    assign vote_tick = tick && (os_q == V2);
    assign wrap      = tick && (os_q == OS_LAST);

    // State and datapath registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            os_q       <= '0;
            idx_q      <= '0;
            stp_q      <= 1'b0;
            shf_q      <= '0;
            perr_int_q <= 1'b0;
            ferr_int_q <= 1'b0;
            req_q      <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            os_q       <= os_d;
            idx_q      <= idx_d;
            stp_q      <= stp_d;
            shf_q      <= shf_d;
            perr_int_q <= perr_int_d;
            ferr_int_q <= ferr_int_d;
            req_q      <= req_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    // Frame sequencing, vote consumption and consumer handshake.
    always_comb begin
        state_d    = state_q;
        os_d       = os_q;
        idx_d      = idx_q;
        stp_d      = stp_q;
        shf_d      = shf_q;
        perr_int_d = perr_int_q;
        ferr_int_d = ferr_int_q;
        req_d      = req_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;

        if (req_q && ack) begin
            req_d = 1'b0;
            ovr_d = 1'b0;
        end

        if (tick && state_q != S_IDLE && state_q != S_DONE) begin
            os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                os_d = '0;
                if (tick && !rs_q) begin
                    state_d    = S_START;
                    idx_d      = '0;
                    stp_d      = 1'b0;
                    shf_d      = '0;
                    perr_int_d = 1'b0;
                    ferr_int_d = 1'b0;
                end
            end
            S_START: begin
                if (vote_tick && vote) begin
                    state_d = S_IDLE;
                    os_d    = '0;
                end else if (wrap) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (vote_tick) begin
                    shf_d = {vote, shf_q[DATA_BITS-1:1]};
                end
                if (wrap) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (vote_tick) begin
                    perr_int_d = (((^shf_q) ^ vote) != ODD);
                end
                if (wrap) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (vote_tick) begin
                    if (!vote) ferr_int_d = 1'b1;
                    if (stp_q == STOP_LST) begin
                        state_d = S_DONE;
                        os_d    = '0;
                    end
                end
                if (wrap && stp_q != STOP_LST) begin
                    stp_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                os_d    = '0;
                if (!req_q && !ack_q) begin
                    req_d  = 1'b1;
                    data_d = shf_q;
                    perr_d = perr_int_q;
                    ferr_d = ferr_int_q;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                os_d    = '0;
            end
        endcase
    end

    assign req     = req_q;
    assign data    = data_q;
    assign perr    = perr_q;
    assign ferr    = ferr_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 (DIV=1), 8E1 (DIV=2), 8O1 (DIV=1).
// Expected values are hand-computed per vector.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       clr;
    logic       rcv  [3];
    logic       ack  [3];
    logic       req  [3];
    logic [7:0] dat  [3];
    logic       perr [3];
    logic       ferr [3];
    logic       ovr  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.DIV(1), .OS(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .clr(clr), .rcv(rcv[0]), .ack(ack[0]), .req(req[0]),
        .data(dat[0]), .perr(perr[0]), .ferr(ferr[0]), .overrun(ovr[0])
    );

    uart_rx_param #(.DIV(2), .OS(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .clr(clr), .rcv(rcv[1]), .ack(ack[1]), .req(req[1]),
        .data(dat[1]), .perr(perr[1]), .ferr(ferr[1]), .overrun(ovr[1])
    );

    uart_rx_param #(.DIV(1), .OS(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .clr(clr), .rcv(rcv[2]), .ack(ack[2]), .req(req[2]),
        .data(dat[2]), .perr(perr[2]), .ferr(ferr[2]), .overrun(ovr[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bclk(input int u);
        return (u == 1) ? 32 : 16;
    endfunction

    task automatic drive(input int u, input logic v);
        rcv[u] = v;
        repeat (bclk(u)) @(negedge clk);
    endtask

    task automatic idle(input int u, input int nbits);
        rcv[u] = 1'b1;
        repeat (nbits * bclk(u)) @(negedge clk);
    endtask

    task automatic send(input int u, input logic [7:0] d, input bit hasp,
                        input logic p, input logic stopv);
        drive(u, 1'b0);
        for (int i = 0; i < 8; i++) drive(u, d[i]);
        if (hasp) drive(u, p);
        drive(u, stopv);
        rcv[u] = 1'b1;
    endtask

    task automatic ackp(input int u, input string tag);
        ack[u] = 1'b1;
        @(negedge clk);
        check(tag, req[u], 1'b0);
        ack[u] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rcv[i] = 1'b1;
            ack[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_req",  req[0],  1'b0);
        check("rst_data", dat[0],  8'h00);
        check("rst_perr", perr[0], 1'b0);
        check("rst_ferr", ferr[0], 1'b0);
        check("rst_ovr",  ovr[0],  1'b0);
        clr = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        check("a5_req",  req[0],  1'b1);
        check("a5_data", dat[0],  8'hA5);
        check("a5_perr", perr[0], 1'b0);
        check("a5_ferr", ferr[0], 1'b0);
        repeat (50) @(negedge clk);
        check("a5_hold", req[0], 1'b1);
        ackp(0, "a5_ack");

        // 3-tick glitch on idle line
        rcv[0] = 1'b0;
        repeat (3) @(negedge clk);
        rcv[0] = 1'b1;
        repeat (40) @(negedge clk);
        check("gl_req",  req[0],  1'b0);
        check("gl_ferr", ferr[0], 1'b0);
        check("gl_ovr",  ovr[0],  1'b0);
        send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        check("3c_req",  req[0], 1'b1);
        check("3c_data", dat[0], 8'h3C);
        ackp(0, "3c_ack");

        // stop bit forced low
        send(0, 8'h96, 1'b0, 1'b0, 1'b0);
        idle(0, 2);
        check("fe_req",  req[0],  1'b1);
        check("fe_data", dat[0],  8'h96);
        check("fe_ferr", ferr[0], 1'b1);
        ackp(0, "fe_ack");

        // back-to-back, ack held low
        send(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send(0, 8'h22, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        check("ov_req",  req[0], 1'b1);
        check("ov_data", dat[0], 8'h11);
        check("ov_flag", ovr[0], 1'b1);
        ackp(0, "ov_ack");
        check("ov_clr", ovr[0], 1'b0);
        send(0, 8'h33, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        check("33_req",  req[0], 1'b1);
        check("33_data", dat[0], 8'h33);
        check("33_ovr",  ovr[0], 1'b0);
        ackp(0, "33_ack");

        // clr in the middle of data bit 4
        drive(0, 1'b0);
        for (int i = 0; i < 4; i++) drive(0, 1'b0);
        rcv[0] = 1'b0;
        repeat (8) @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        check("cl_req",  req[0],  1'b0);
        check("cl_data", dat[0],  8'h00);
        check("cl_ferr", ferr[0], 1'b0);
        check("cl_ovr",  ovr[0],  1'b0);
        rcv[0] = 1'b1;
        repeat (4) @(negedge clk);
        clr = 1'b0;
        idle(0, 2);
        check("cl_idle", req[0], 1'b0);
        send(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        check("5a_req",  req[0],  1'b1);
        check("5a_data", dat[0],  8'h5A);
        check("5a_perr", perr[0], 1'b0);
        check("5a_ferr", ferr[0], 1'b0);
        ackp(0, "5a_ack");

        // 8E1, DIV=2
        send(1, 8'h03, 1'b1, 1'b0, 1'b1);
        idle(1, 1);
        check("e0_req",  req[1],  1'b1);
        check("e0_data", dat[1],  8'h03);
        check("e0_perr", perr[1], 1'b0);
        ackp(1, "e0_ack");
        send(1, 8'h03, 1'b1, 1'b1, 1'b1);
        idle(1, 1);
        check("e1_req",  req[1],  1'b1);
        check("e1_perr", perr[1], 1'b1);
        check("e1_ferr", ferr[1], 1'b0);
        ackp(1, "e1_ack");

        // 8O1
        send(2, 8'h03, 1'b1, 1'b1, 1'b1);
        idle(2, 1);
        check("o1_req",  req[2],  1'b1);
        check("o1_data", dat[2],  8'h03);
        check("o1_perr", perr[2], 1'b0);
        ackp(2, "o1_ack");
        send(2, 8'h03, 1'b1, 1'b0, 1'b1);
        idle(2, 1);
        check("o0_req",  req[2],  1'b1);
        check("o0_perr", perr[2], 1'b1);
        ackp(2, "o0_ack");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
